// File: rtl/pfa_seq_adder_ctrl.sv
// Multi-cycle adder: one SLICE-bit partial-full-adder slice reused over a WIDTH-bit word, LSB slice first.
// Optional subtract mode is enabled by defining PFA_SEQ_SUB_EN (adds the 'sub' input).
module pfa_seq_adder_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PFA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             p_all
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_next;
    logic [IDXW-1:0]  idx_reg;
    logic             carry_reg, p_acc_reg;
    logic             cout_reg, ovf_reg, zero_reg, p_all_reg;

    logic [SLICE-1:0] sl_a, sl_b, sl_p, sl_g, sl_s;
    logic [SLICE:0]   c;
    logic             accept, last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef PFA_SEQ_SUB_EN
    // Subtraction is a + ~b + 1; cout=1 then means no borrow.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign sl_a = a_reg[idx_reg*SLICE +: SLICE];
    assign sl_b = b_reg[idx_reg*SLICE +: SLICE];
    assign c[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_pfa
            assign sl_p[gi]   = sl_a[gi] ^ sl_b[gi];
            assign sl_g[gi]   = sl_a[gi] & sl_b[gi];
            assign c[gi+1]    = sl_g[gi] | (sl_p[gi] & c[gi]);
            assign sl_s[gi]   = sl_p[gi] ^ c[gi];
        end
    endgenerate

    assign last = (idx_reg == LAST_IDX);

    always_comb begin
        sum_next = sum_reg;
        sum_next[idx_reg*SLICE +: SLICE] = sl_s;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                accept     = start;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            p_acc_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            p_all_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b_load;
            idx_reg   <= '0;
            carry_reg <= c_load;
            p_acc_reg <= 1'b1;
        end else if (state_reg == RUN) begin
            sum_reg   <= sum_next;
            carry_reg <= c[SLICE];
            p_acc_reg <= p_acc_reg & (&sl_p);
            idx_reg   <= last ? '0 : idx_reg + 1'b1;
            // Flags only change on the final slice so they hold between operations.
            if (last) begin
                cout_reg  <= c[SLICE];
                ovf_reg   <= c[SLICE-1] ^ c[SLICE];
                p_all_reg <= p_acc_reg & (&sl_p);
                zero_reg  <= (sum_next == '0);
            end
        end
    end

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign sum   = sum_reg;
    assign cout  = cout_reg;
    assign ovf   = ovf_reg;
    assign zero  = zero_reg;
    assign p_all = p_all_reg;

endmodule
